// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and default timing for the SRAM initiator.
// SRAM_CTRL_BYTE_MERGE_EN adds the MERGE state used for read-modify-write
// of partial (single-byte) writes.
package sram_ctrl_pkg;

  localparam int DEF_WR_CYCLES = 3;
  localparam int DEF_RD_CYCLES = 2;

  // Strobe vector order: {ce_n, oe_n, we_n, lb_n, ub_n}
  localparam logic [4:0] STB_OFF  = 5'b11111;
  localparam logic [4:0] STB_READ = 5'b00100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3
`ifdef SRAM_CTRL_BYTE_MERGE_EN
    , S_MERGE = 3'd4
`endif
  } state_t;

  function automatic logic [4:0] stb_write(input logic [1:0] be);
    return {3'b000, ~be[0], ~be[1]};
  endfunction

endpackage

// File: rtl/sram_ctrl_byte_merge.sv
// sram_ctrl_byte_merge: combinational byte lane select; lanes with be set
// take new_data, the others keep old_data. Used only when
// SRAM_CTRL_BYTE_MERGE_EN is defined.
module sram_ctrl_byte_merge #(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        be,
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  output logic [DATA_W-1:0] merged
);
  localparam int H = DATA_W / 2;

  assign merged = {be[1] ? new_data[DATA_W-1:H] : old_data[DATA_W-1:H],
                   be[0] ? new_data[H-1:0]      : old_data[H-1:0]};
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word request/done initiator for the 16-bit async SRAM.
// All SRAM-facing signals are registered and only change on state changes.
// Optional: SRAM_CTRL_BYTE_MERGE_EN turns partial writes into
// read / merge / full-word write.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int WR_CYCLES = DEF_WR_CYCLES,
  parameter int RD_CYCLES = DEF_RD_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam logic [1:0] WR_LOAD = 2'(WR_CYCLES - 1);
  localparam logic [1:0] RD_LOAD = 2'(RD_CYCLES - 1);

  state_t            state, nstate;
  logic [1:0]        timer, ntimer;
  logic [1:0]        be_q, nbe;
  logic [4:0]        stb, nstb;
  logic              ndone;
  logic [DATA_W-1:0] nrdata, ndin;
  logic [ADDR_W-1:0] naddr;

`ifdef SRAM_CTRL_BYTE_MERGE_EN
  logic              merge_q, nmerge;
  logic [DATA_W-1:0] merged;

  sram_ctrl_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .be       (be_q),
    .old_data (sram_dout),
    .new_data (sram_din),
    .merged   (merged)
  );
`endif

  assign ready = (state == S_IDLE);
  assign {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} = stb;

  // State and all SRAM-facing registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= 2'd0;
      be_q      <= 2'b00;
      stb       <= STB_OFF;
      done      <= 1'b0;
      rdata     <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
`ifdef SRAM_CTRL_BYTE_MERGE_EN
      merge_q   <= 1'b0;
`endif
    end else begin
      state     <= nstate;
      timer     <= ntimer;
      be_q      <= nbe;
      stb       <= nstb;
      done      <= ndone;
      rdata     <= nrdata;
      sram_addr <= naddr;
      sram_din  <= ndin;
`ifdef SRAM_CTRL_BYTE_MERGE_EN
      merge_q   <= nmerge;
`endif
    end
  end

  // Next state plus the values the registered strobes/bus take on entry.
  always_comb begin
    nstate = state;
    ntimer = timer;
    nbe    = be_q;
    nstb   = stb;
    ndone  = 1'b0;
    nrdata = rdata;
    naddr  = sram_addr;
    ndin   = sram_din;
`ifdef SRAM_CTRL_BYTE_MERGE_EN
    nmerge = merge_q;
`endif
    case (state)
      S_IDLE: begin
        if (req) begin
          naddr = addr;
          ndin  = wdata;
          nbe   = be;
          if (we && (be == 2'b00)) begin
            // Nothing to write: complete without touching the memory.
            ndone = 1'b1;
          end else if (we) begin
`ifdef SRAM_CTRL_BYTE_MERGE_EN
            if (be != 2'b11) begin
              nstate = S_READ;
              ntimer = RD_LOAD;
              nstb   = STB_READ;
              nmerge = 1'b1;
            end else begin
`endif
              nstate = S_WRITE;
              ntimer = WR_LOAD;
              nstb   = stb_write(be);
`ifdef SRAM_CTRL_BYTE_MERGE_EN
            end
`endif
          end else begin
            nstate = S_READ;
            ntimer = RD_LOAD;
            nstb   = STB_READ;
`ifdef SRAM_CTRL_BYTE_MERGE_EN
            nmerge = 1'b0;
`endif
          end
        end
      end
      S_WRITE: begin
        if (timer == 2'd0) begin
          nstate = S_IDLE;
          nstb   = STB_OFF;
          ndone  = 1'b1;
        end else begin
          ntimer = timer - 2'd1;
        end
      end
      S_READ: begin
        if (timer == 2'd0) begin
          nstb   = STB_OFF;
`ifdef SRAM_CTRL_BYTE_MERGE_EN
          nstate = merge_q ? S_MERGE : S_CAPTURE;
`else
          nstate = S_CAPTURE;
`endif
        end else begin
          ntimer = timer - 2'd1;
        end
      end
      S_CAPTURE: begin
        nrdata = sram_dout;
        nstate = S_IDLE;
        ndone  = 1'b1;
      end
`ifdef SRAM_CTRL_BYTE_MERGE_EN
      // Merged word goes back as a full-word write; rdata is left alone.
      S_MERGE: begin
        ndin   = merged;
        nstate = S_WRITE;
        ntimer = WR_LOAD;
        nstb   = stb_write(2'b11);
      end
`endif
      default: begin
        nstate = S_IDLE;
        nstb   = STB_OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed vector table, reset-abort sequence and randomized
// traffic against a word-level memory reference model.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_BYTE_MERGE_EN
  localparam bit MRG = 1'b1;
`else
  localparam bit MRG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [1:0]  be;
  logic [15:0] addr, wdata;
  logic        ready, done;
  logic [15:0] rdata;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
  logic [15:0] sram_addr, sram_din, sram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  sram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-strobed writes, dout loaded on each read cycle.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_din[7:0];
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_din[15:8];
    end else if (!sram_ce_n && !sram_oe_n) begin
      sram_dout <= mem[sram_addr[7:0]];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          ce_cyc;
    int          we_cyc;
    logic [15:0] rd;
    logic        lb;
    logic        ub;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request at the current negedge (ready expected) and watch it
  // until done, returning at the negedge of the done cycle.
  task automatic apply(input vec_t v);
    int lat, ce_cyc, we_cyc, addr_bad;
    logic lb, ub;
    lat = 0; ce_cyc = 0; we_cyc = 0; addr_bad = 0; lb = 1'b1; ub = 1'b1;
    chk("ready_before_req", ready, 1);
    req = 1'b1; we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!sram_ce_n) begin
        ce_cyc++;
        if (sram_addr !== v.addr) addr_bad++;
      end
      if (!sram_ce_n && !sram_we_n) begin
        we_cyc++; lb = sram_lb_n; ub = sram_ub_n;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("done_latency", lat, v.lat);
    chk("ce_low_cycles", ce_cyc, v.ce_cyc);
    chk("we_low_cycles", we_cyc, v.we_cyc);
    chk("addr_stable", addr_bad, 0);
    chk("rdata", rdata, v.rd);
    chk("ready_at_done", ready, 1);
    chk("ce_high_at_done", sram_ce_n, 1);
    if (v.we && v.be != 2'b00) begin
      chk("lb_n", lb, v.lb);
      chk("ub_n", ub, v.ub);
    end
  endtask

  function automatic int ref_lat(input logic w, input logic [1:0] b);
    if (w && b == 2'b00) return 1;
    if (w && b != 2'b11 && MRG) return 7;
    return 4;
  endfunction

  function automatic int ref_ce(input logic w, input logic [1:0] b);
    if (w && b == 2'b00) return 0;
    if (w && b != 2'b11 && MRG) return 5;
    return w ? 3 : 2;
  endfunction

  vec_t        vt [11];
  vec_t        v;
  logic [15:0] ref_mem [16];
  logic [15:0] last_rd, mask;
  int          done_cnt;

  initial begin
    // Directed table: {we, be, addr, wdata, lat, ce, we, rdata, lb_n, ub_n}
    vt[0]  = '{1'b1, 2'b11, 16'h0010, 16'hBEEF, 4, 3, 3, 16'h0000, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 2'b11, 16'h0010, 16'h0000, 4, 2, 0, 16'hBEEF, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 2'b11, 16'h0020, 16'h1234, 4, 3, 3, 16'hBEEF, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 2'b11, 16'h0020, 16'h0000, 4, 2, 0, 16'h1234, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 2'b11, 16'h0030, 16'hAABB, 4, 3, 3, 16'h1234, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 2'b01, 16'h0030, 16'h00CC, MRG ? 7 : 4, MRG ? 5 : 3, 3,
               16'h1234, 1'b0, MRG ? 1'b0 : 1'b1};
    vt[6]  = '{1'b0, 2'b11, 16'h0030, 16'h0000, 4, 2, 0, 16'hAACC, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 2'b10, 16'h0030, 16'h5500, MRG ? 7 : 4, MRG ? 5 : 3, 3,
               16'hAACC, MRG ? 1'b0 : 1'b1, 1'b0};
    vt[8]  = '{1'b0, 2'b11, 16'h0030, 16'h0000, 4, 2, 0, 16'h55CC, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 2'b00, 16'h0030, 16'hFFFF, 1, 0, 0, 16'h55CC, 1'b0, 1'b0};
    vt[10] = '{1'b0, 2'b11, 16'h0030, 16'h0000, 4, 2, 0, 16'h55CC, 1'b0, 1'b0};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 2'b00; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'h1F);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive entries are issued in the previous done cycle.
    for (int i = 0; i < 11; i++) apply(vt[i]);

    // Reset during cycle 2 of a read.
    req = 1'b1; we = 1'b0; be = 2'b11; addr = 16'h0010;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("abort_read_active", sram_ce_n, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'h1F);
    chk("abort_ready", ready, 1);
    chk("abort_rdata", rdata, 0);
    chk("abort_addr", sram_addr, 0);
    chk("abort_din", sram_din, 0);
    done_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt, 0);

    // Randomized traffic over 0x40..0x4F against the word-level model.
    last_rd = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'($urandom);
      v = '{1'b1, 2'b11, 16'h0040 + 16'(i), ref_mem[i], 4, 3, 3, last_rd, 1'b0, 1'b0};
      apply(v);
    end
    for (int k = 0; k < 100; k++) begin
      int i;
      i       = $urandom_range(15);
      v.we    = 1'($urandom_range(1));
      v.be    = 2'($urandom_range(3));
      v.addr  = 16'h0040 + 16'(i);
      v.wdata = 16'($urandom);
      v.lat   = ref_lat(v.we, v.be);
      v.ce_cyc = ref_ce(v.we, v.be);
      v.we_cyc = (v.we && v.be != 2'b00) ? 3 : 0;
      if (v.we) begin
        mask = {{8{v.be[1]}}, {8{v.be[0]}}};
        ref_mem[i] = (ref_mem[i] & ~mask) | (v.wdata & mask);
      end else begin
        last_rd = ref_mem[i];
      end
      v.rd = last_rd;
      v.lb = (MRG && v.be != 2'b11) ? 1'b0 : ~v.be[0];
      v.ub = (MRG && v.be != 2'b11) ? 1'b0 : ~v.be[1];
      apply(v);
    end
    for (int i = 0; i < 16; i++) chk("final_mem", mem[8'h40 + 8'(i)], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
